// File: rtl/vga_pkg.sv
// Shared timing constants, 12-bit colour constants and pattern-select encoding for the VGA pixel path.
// No logic and no latency. Backpressure does not apply here.
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int CW       = 10;
    localparam int BOX_SIZE = 32;

    typedef logic [11:0] rgb_t;

    localparam rgb_t WHITE   = 12'hFFF;
    localparam rgb_t YELLOW  = 12'hFF0;
    localparam rgb_t CYAN    = 12'h0FF;
    localparam rgb_t GREEN   = 12'h0F0;
    localparam rgb_t MAGENTA = 12'hF0F;
    localparam rgb_t RED     = 12'hF00;
    localparam rgb_t BLUE    = 12'h00F;
    localparam rgb_t BLACK   = 12'h000;
    localparam rgb_t NAVY    = 12'h004;

    typedef enum logic [1:0] {
        BARS  = 2'd0,
        CHECK = 2'd1,
        BOX   = 2'd2,
        GRAD  = 2'd3
    } mode_t;

    // Bar 0 sits at the left edge of the screen.
    function automatic rgb_t bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    return WHITE;
            3'd1:    return YELLOW;
            3'd2:    return CYAN;
            3'd3:    return GREEN;
            3'd4:    return MAGENTA;
            3'd5:    return RED;
            3'd6:    return BLUE;
            default: return BLACK;
        endcase
    endfunction

endpackage

// File: rtl/vga_box_mover.sv
// Bouncing-box position: advances one pixel per axis on each frame_start and reverses at the screen edges.
// The new position is visible the cycle after frame_start. There is no backpressure: it steps on every frame_start.
module vga_box_mover
    import vga_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          frame_start,
    output logic [CW-1:0] box_x,
    output logic [CW-1:0] box_y
);

    localparam logic [CW-1:0] X_MAX = CW'(H_ACTIVE - BOX_SIZE);
    localparam logic [CW-1:0] Y_MAX = CW'(V_ACTIVE - BOX_SIZE);

    logic dx_neg;
    logic dy_neg;

    // The result is {next direction (1 = moving negative), next position}.
    function automatic logic [CW:0] bounce(input logic neg, input logic [CW-1:0] pos,
                                           input logic [CW-1:0] lim);
        if (!neg && pos == lim)
            return {1'b1, pos - 1'b1};
        else if (neg && pos == '0)
            return {1'b0, CW'(1)};
        else
            return {neg, neg ? pos - 1'b1 : pos + 1'b1};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            box_x  <= '0;
            box_y  <= '0;
            dx_neg <= 1'b0;
            dy_neg <= 1'b0;
        end else if (frame_start) begin
            {dx_neg, box_x} <= bounce(dx_neg, box_x, X_MAX);
            {dy_neg, box_y} <= bounce(dy_neg, box_y, Y_MAX);
        end
    end

endmodule

// File: rtl/vga_pattern_gen.sv
// Test-pattern colour stage behind the VGA timing counters. It drives the R/G/B pins and the syncs re-aligned to them.
// The latency is 2 clk from any input to R/G/B and h_sync/v_sync. There is no backpressure: it accepts one pixel every clk.
module vga_pattern_gen
    import vga_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic [CW-1:0] h_count,
    input  logic [CW-1:0] v_count,
    input  logic          video_on,
    input  logic          h_sync_in,
    input  logic          v_sync_in,
    input  logic [1:0]    mode,
    output logic [3:0]    R,
    output logic [3:0]    G,
    output logic [3:0]    B,
    output logic          h_sync,
    output logic          v_sync
);

    localparam int            BAR_W = H_ACTIVE / 8;
    localparam logic [CW:0]   BOX_W = (CW+1)'(BOX_SIZE);

    logic          frame_start;
    logic [CW-1:0] h_q, v_q;
    logic          von_q, hs_q, vs_q;
    mode_t         mode_q;
    logic [7:0]    frame_cnt;
    logic [CW-1:0] box_x, box_y;
    logic [2:0]    bar_idx;
    logic          in_x, in_y;
    rgb_t          pix;

    assign frame_start = (h_count == '0) && (v_count == '0);

    vga_box_mover u_box (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .box_x       (box_x),
        .box_y       (box_y)
    );

    // Stage 1. The mode and frame count update together with the first pixel of the frame, so the new pattern starts exactly at (0,0).
    always_ff @(posedge clk) begin
        if (rst) begin
            h_q       <= '0;
            v_q       <= '0;
            von_q     <= 1'b0;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            mode_q    <= BARS;
            frame_cnt <= '0;
        end else begin
            h_q   <= h_count;
            v_q   <= v_count;
            von_q <= video_on;
            hs_q  <= h_sync_in;
            vs_q  <= v_sync_in;
            if (frame_start) begin
                mode_q    <= mode_t'(mode);
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

    // Bar select uses constant thresholds, so no divider is needed.
    always_comb begin
        bar_idx = 3'd7;
        for (int i = 6; i >= 0; i--) begin
            if (h_q < CW'((i + 1) * BAR_W))
                bar_idx = 3'(i);
        end
    end

    // The box compare is one bit wider, so box_x + BOX_SIZE cannot wrap.
    always_comb begin
        in_x = ({1'b0, h_q} >= {1'b0, box_x}) && ({1'b0, h_q} < ({1'b0, box_x} + BOX_W));
        in_y = ({1'b0, v_q} >= {1'b0, box_y}) && ({1'b0, v_q} < ({1'b0, box_y} + BOX_W));
    end

    always_comb begin
        pix = BLACK;
        case (mode_q)
            BARS:  pix = bar_colour(bar_idx);
            CHECK: pix = (h_q[5] ^ v_q[5]) ? WHITE : BLACK;
            BOX:   pix = (in_x && in_y) ? RED : NAVY;
            GRAD:  pix = {h_q[9:6], v_q[8:5], frame_cnt[3:0]};
        endcase
        if (!von_q)
            pix = BLACK;
    end

    // Stage 2. The syncs take this register too, so sync and colour stay aligned.
    always_ff @(posedge clk) begin
        if (rst) begin
            {R, G, B} <= BLACK;
            h_sync    <= 1'b1;
            v_sync    <= 1'b1;
        end else begin
            {R, G, B} <= pix;
            h_sync    <= hs_q;
            v_sync    <= vs_q;
        end
    end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench for vga_pattern_gen. Stimulus vectors carry expected colour, and each is checked exactly 2 clk after it is driven.
module tb_vga_pattern_gen;
    import vga_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] h_count, v_count;
    logic       video_on, h_sync_in, v_sync_in;
    logic [1:0] mode;
    logic [3:0] R, G, B;
    logic       h_sync, v_sync;

    always #5 clk = ~clk;

    vga_pattern_gen dut (
        .clk       (clk),
        .rst       (rst),
        .h_count   (h_count),
        .v_count   (v_count),
        .video_on  (video_on),
        .h_sync_in (h_sync_in),
        .v_sync_in (v_sync_in),
        .mode      (mode),
        .R         (R),
        .G         (G),
        .B         (B),
        .h_sync    (h_sync),
        .v_sync    (v_sync)
    );

    typedef struct {
        logic       rst;
        logic [9:0] h, v;
        logic       von, hs, vs;
        logic [1:0] md;
        logic [11:0] rgb;
        string      name;
    } vec_t;

    typedef struct {
        logic        chk;
        logic [13:0] exp;
        string       name;
    } pend_t;

    int    checks = 0;
    int    errors = 0;
    pend_t pend0, pend1;
    vec_t  tbl[$];

    function automatic vec_t mk(input logic r, input int h, input int v, input logic von,
                                input logic [1:0] md, input logic [11:0] rgb, input string nm,
                                input logic hs, input logic vs);
        vec_t t;
        t.rst = r; t.h = 10'(h); t.v = 10'(v); t.von = von; t.hs = hs; t.vs = vs;
        t.md = md; t.rgb = rgb; t.name = nm;
        return t;
    endfunction

    // The position after n frame starts, for a box bouncing between 0 and m.
    function automatic int tri_pos(input int n, input int m);
        int r;
        r = n % (2 * m);
        return (r <= m) ? r : 2 * m - r;
    endfunction

    // Check the output of the vector driven two steps ago, then drive this one. A reset also forces the next sample to black with the syncs idle.
    task automatic step(input vec_t t);
        if (pend1.chk) begin
            checks++;
            if ({R, G, B, h_sync, v_sync} !== pend1.exp) begin
                errors++;
                $display("FAIL %s: got rgb=%h hs=%b vs=%b, expected rgb=%h hs=%b vs=%b",
                         pend1.name, {R, G, B}, h_sync, v_sync,
                         pend1.exp[13:2], pend1.exp[1], pend1.exp[0]);
            end
        end
        pend1      = pend0;
        pend0.chk  = (t.name != "");
        pend0.exp  = t.rst ? {12'h000, 2'b11} : {t.rgb, t.hs, t.vs};
        pend0.name = t.name;
        if (t.rst) begin
            pend1.chk  = 1'b1;
            pend1.exp  = {12'h000, 2'b11};
            pend1.name = {t.name, "_next"};
        end
        rst = t.rst; h_count = t.h; v_count = t.v; video_on = t.von;
        h_sync_in = t.hs; v_sync_in = t.vs; mode = t.md;
        @(negedge clk);
    endtask

    task automatic run_tbl();
        foreach (tbl[i]) step(tbl[i]);
        tbl.delete();
    endtask

    initial begin
        logic [11:0] bars [8];
        int bx, by;
        bars = '{WHITE, YELLOW, CYAN, GREEN, MAGENTA, RED, BLUE, BLACK};
        pend0.chk = 1'b0; pend0.exp = '0; pend0.name = "";
        pend1 = pend0;

        // The colour stays blank while in reset, even with video_on and the syncs active. After release, the first colour shows exactly 2 clk later.
        tbl.push_back(mk(1, 10, 10, 1, 0, 12'h000, "rst_a", 0, 0));
        tbl.push_back(mk(1, 10, 10, 1, 0, 12'h000, "rst_b", 0, 0));
        tbl.push_back(mk(1, 10, 10, 1, 0, 12'h000, "rst_c", 0, 0));
        tbl.push_back(mk(0, 10, 10, 1, 0, WHITE,   "rel_first", 1, 1));
        tbl.push_back(mk(0, 85, 10, 1, 0, YELLOW,  "bar_yellow", 1, 1));
        // Checkerboard, and blanking that overrides the pattern.
        tbl.push_back(mk(0, 0, 0, 1, 1, BLACK,   "chk_0_0", 1, 1));
        tbl.push_back(mk(0, 32, 0, 1, 1, WHITE,  "chk_32_0", 1, 1));
        tbl.push_back(mk(0, 32, 32, 1, 1, BLACK, "chk_32_32", 1, 1));
        tbl.push_back(mk(0, 40, 10, 1, 1, WHITE, "chk_40_10", 1, 1));
        tbl.push_back(mk(0, 40, 10, 0, 1, BLACK, "chk_blank", 1, 1));
        // A mode change mid-frame takes effect only at the next (0,0).
        tbl.push_back(mk(0, 0, 0, 1, 0, WHITE,      "fs_bars", 1, 1));
        tbl.push_back(mk(0, 100, 200, 1, 1, YELLOW, "mid_mode_chg", 1, 1));
        tbl.push_back(mk(0, 330, 479, 1, 1, MAGENTA,"bars_to_eof", 1, 1));
        tbl.push_back(mk(0, 0, 0, 1, 1, BLACK,      "fs_check", 1, 1));
        tbl.push_back(mk(0, 100, 0, 1, 0, WHITE,    "check_held", 1, 1));
        tbl.push_back(mk(0, 700, 500, 0, 0, BLACK,  "blank_offscreen", 1, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0, WHITE,      "fs_bars2", 1, 1));
        run_tbl();

        // A full bar sweep on one line, with an h_sync_in pulse and a v_sync_in pulse.
        for (int x = 0; x < 640; x++)
            step(mk(0, x, 1, 1, 0, bars[x / 80], "bar_sweep",
                    !(x >= 300 && x < 308), !(x >= 400 && x < 402)));

        // The box moves from a fresh reset through 700 frame starts, with probes at the bounce points.
        step(mk(1, 5, 5, 1, 2, 12'h000, "rst2", 1, 1));
        step(mk(1, 5, 5, 1, 2, 12'h000, "rst2b", 1, 1));
        for (int n = 1; n <= 700; n++) begin
            step(mk(0, 0, 0, 1, 2, NAVY, "box_fs", 1, 1));
            if (n == 448 || n == 608 || n == 609 || n == 700) begin
                bx = tri_pos(n, 608);
                by = tri_pos(n, 448);
                step(mk(0, bx, by, 1, 2, RED,           "box_tl", 1, 1));
                step(mk(0, bx + 31, by + 31, 1, 2, RED, "box_br", 1, 1));
                step(mk(0, bx - 1, by, 1, 2, NAVY,      "box_left_out", 1, 1));
                step(mk(0, bx, by - 1, 1, 2, NAVY,      "box_above_out", 1, 1));
                if (bx + 32 < 640) step(mk(0, bx + 32, by, 1, 2, NAVY, "box_right_out", 1, 1));
                if (by + 32 < 480) step(mk(0, bx, by + 32, 1, 2, NAVY, "box_below_out", 1, 1));
            end
            if (n == 608) begin
                step(mk(0, 608, 288, 1, 2, RED,  "box_608", 1, 1));
                step(mk(0, 607, 288, 1, 2, NAVY, "box_608_left", 1, 1));
            end
            if (n == 609) begin
                step(mk(0, 607, 287, 1, 2, RED,  "box_609", 1, 1));
                step(mk(0, 639, 287, 1, 2, NAVY, "box_609_right", 1, 1));
            end
        end

        // Gradient, then a mid-frame reset: the frame count, mode and box all restart from zero.
        tbl.push_back(mk(0, 0, 0, 1, 3, 12'h00D,     "fs_grad", 1, 1));
        tbl.push_back(mk(0, 320, 240, 1, 3, 12'h57D, "grad_mid", 1, 1));
        tbl.push_back(mk(0, 320, 240, 1, 3, 12'h57D, "grad_mid2", 0, 1));
        tbl.push_back(mk(1, 320, 240, 1, 3, 12'h000, "rst_mid", 0, 0));
        tbl.push_back(mk(0, 320, 240, 1, 3, MAGENTA, "after_rst_bars", 1, 1));
        tbl.push_back(mk(0, 0, 0, 1, 3, 12'h001,     "fs_grad_cnt1", 1, 1));
        tbl.push_back(mk(0, 320, 240, 1, 3, 12'h571, "grad_cnt1", 1, 1));
        tbl.push_back(mk(0, 0, 0, 1, 2, NAVY,        "fs_box_restart", 1, 1));
        tbl.push_back(mk(0, 2, 2, 1, 2, RED,         "box_restart_in", 1, 1));
        tbl.push_back(mk(0, 1, 2, 1, 2, NAVY,        "box_restart_out", 1, 1));
        tbl.push_back(mk(0, 5, 5, 0, 0, BLACK,       "", 1, 1));
        tbl.push_back(mk(0, 5, 5, 0, 0, BLACK,       "", 1, 1));
        run_tbl();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
